// File: rtl/flag_pkg.sv
// flag_pkg: shared op, flag-index and branch-condition encodings for flag_regfile (stack option FLAG_STACK_EN)
package flag_pkg;
  typedef enum logic [1:0] {FLAG_LOAD, FLAG_SET, FLAG_CLR, FLAG_TGL} flag_op_e;
  typedef enum logic [2:0] {
    COND_ALWAYS, COND_C, COND_NC, COND_Z, COND_NZ, COND_N, COND_V, COND_HI
  } cond_e;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/flag_stack.sv
// flag_stack: LIFO shadow stack of flag words with count, full/empty and a sticky misuse error
module flag_stack #(
  parameter int NFLAGS = 4,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              push,
  input  logic              pop,
  input  logic [NFLAGS-1:0] din,
  output logic [NFLAGS-1:0] top,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              err,
  output logic              pop_ok
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [NFLAGS-1:0] mem [DEPTH];
  logic push_ok, bad;
  logic [AW-1:0] wr_addr, rd_addr;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push_ok = enable & push & ~pop & ~full;
  assign pop_ok = enable & pop & ~push & ~empty;
  assign bad = enable & ((push & pop) | (push & full) | (pop & empty));
  assign wr_addr = AW'(count);
  assign rd_addr = AW'(count - CW'(1));
  assign top = mem[rd_addr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      err <= 1'b0;
    end else begin
      if (push_ok) count <= count + CW'(1);
      else if (pop_ok) count <= count - CW'(1);
      if (bad) err <= 1'b1;
    end
  end
  // contents need no reset: count alone decides what is visible
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_addr] <= din;
  end
endmodule

// File: rtl/flag_regfile.sv
// flag_regfile: masked load/set/clear/toggle status flags with branch-condition evaluator
// Optional shadow stack built when FLAG_STACK_EN is defined.
module flag_regfile
  import flag_pkg::*;
#(
  parameter int NFLAGS = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   op,
  input  logic [NFLAGS-1:0]            mask,
  input  logic [NFLAGS-1:0]            din,
  input  logic                         push,
  input  logic                         pop,
  input  logic [2:0]                   cond_sel,
  output logic [NFLAGS-1:0]            flags,
  output logic                         cond_true,
  output logic [$clog2(DEPTH+1)-1:0]   stk_count,
  output logic                         stk_full,
  output logic                         stk_empty,
  output logic                         stk_err
);
  flag_op_e opc;
  logic [NFLAGS-1:0] opv, upd, nxt, stk_top;
  logic [3:0] f4;
  logic [7:0] cv;
  logic pop_ok;
  assign opc = flag_op_e'(op);
`ifdef FLAG_STACK_EN
  flag_stack #(.NFLAGS(NFLAGS), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .reset(reset), .enable(enable), .push(push), .pop(pop),
    .din(flags), .top(stk_top), .count(stk_count), .full(stk_full),
    .empty(stk_empty), .err(stk_err), .pop_ok(pop_ok)
  );
`else
  logic unused_stack;
  assign unused_stack = ^{push, pop};
  assign stk_top = '0;
  assign pop_ok = 1'b0;
  assign stk_count = '0;
  assign stk_full = 1'b0;
  assign stk_empty = 1'b1;
  assign stk_err = 1'b0;
`endif
  always_comb begin
    opv = opc == FLAG_LOAD ? din : opc == FLAG_SET ? '1 : opc == FLAG_CLR ? '0 : ~flags;
    upd = (flags & ~mask) | (opv & mask);
    nxt = pop_ok ? stk_top : upd;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags <= '0;
    else if (enable) flags <= nxt;
  end
  // flags beyond NFLAGS read as zero
  assign f4 = 4'(flags);
  assign cv = {f4[FLAG_C] & ~f4[FLAG_Z], f4[FLAG_V], f4[FLAG_N], ~f4[FLAG_Z],
               f4[FLAG_Z], ~f4[FLAG_C], f4[FLAG_C], 1'b1};
  assign cond_true = cv[cond_sel];
endmodule

// File: tb/tb_flag_regfile.sv
// tb_flag_regfile: directed plus random checks of flag_regfile against a queue-based reference model
module tb_flag_regfile;
  localparam int NF = 4;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef FLAG_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [1:0] op = 2'd0;
  logic [NF-1:0] mask = '0, din = '0;
  logic push = 1'b0, pop = 1'b0;
  logic [2:0] cond_sel = 3'd0;
  logic [NF-1:0] flags;
  logic cond_true, stk_full, stk_empty, stk_err;
  logic [CW-1:0] stk_count;
  int compared = 0;
  int mismatched = 0;
  logic [NF-1:0] mf;
  logic merr;
  logic [NF-1:0] q[$];

  flag_regfile #(.NFLAGS(NF), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .mask(mask), .din(din),
    .push(push), .pop(pop), .cond_sel(cond_sel), .flags(flags), .cond_true(cond_true),
    .stk_count(stk_count), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_model(input logic [2:0] s, input logic [NF-1:0] f);
    logic c, z, n, v;
    c = f[0]; z = f[1]; n = f[2]; v = f[3];
    case (s)
      3'd0: return 1'b1;
      3'd1: return c;
      3'd2: return !c;
      3'd3: return z;
      3'd4: return !z;
      3'd5: return n;
      3'd6: return v;
      default: return c && !z;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".flags"}, 32'(flags), 32'(mf));
    check({tag, ".count"}, 32'(stk_count), q.size());
    check({tag, ".empty"}, 32'(stk_empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(stk_full), 32'(q.size() == DEPTH));
    check({tag, ".err"}, 32'(stk_err), 32'(merr));
    check({tag, ".cond"}, 32'(cond_true), 32'(cond_model(cond_sel, mf)));
  endtask

  task automatic model_edge();
    logic restored;
    logic [NF-1:0] rv;
    restored = 1'b0;
    rv = '0;
    if (!enable) return;
    if (STK) begin
      if (push && pop) merr = 1'b1;
      else if (push) begin
        if (q.size() == DEPTH) merr = 1'b1;
        else q.push_back(mf);
      end else if (pop) begin
        if (q.size() == 0) merr = 1'b1;
        else begin
          rv = q.pop_back();
          restored = 1'b1;
        end
      end
    end
    if (restored) mf = rv;
    else
      for (int i = 0; i < NF; i++)
        if (mask[i])
          case (op)
            2'd0: mf[i] = din[i];
            2'd1: mf[i] = 1'b1;
            2'd2: mf[i] = 1'b0;
            default: mf[i] = ~mf[i];
          endcase
  endtask

  task automatic step(input string tag, input logic e, input logic [1:0] o, input logic [NF-1:0] m,
                      input logic [NF-1:0] d, input logic pu, input logic po);
    enable = e; op = o; mask = m; din = d; push = pu; pop = po;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    mf = '0; merr = 1'b0; q.delete();
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    mf = '0; merr = 1'b0;
    #1;
    do_reset();
    step("load", 1, 2'd0, 4'b1111, 4'b1010, 0, 0);
    check("load_val", 32'(flags), 32'b1010);
    cond_sel = 3'd3; #1;
    check("cond_z", 32'(cond_true), 32'd1);
    cond_sel = 3'd1; #1;
    check("cond_c", 32'(cond_true), 32'd0);
    step("set", 1, 2'd1, 4'b0001, 4'b0000, 0, 0);
    check("set_val", 32'(flags), 32'b1011);
    step("tgl", 1, 2'd3, 4'b1100, 4'b0000, 0, 0);
    check("tgl_val", 32'(flags), 32'b0111);
    step("clr", 1, 2'd2, 4'b0010, 4'b0000, 0, 0);
    check("clr_val", 32'(flags), 32'b0101);
    step("hold", 0, 2'd3, 4'b1111, 4'b1111, 1, 0);
    check("hold_val", 32'(flags), 32'b0101);
    step("push", 1, 2'd0, 4'b0000, 4'b0000, 1, 0);
    step("load0", 1, 2'd0, 4'b1111, 4'b0000, 0, 0);
    step("pop", 1, 2'd0, 4'b1111, 4'b1110, 0, 1);
`ifdef FLAG_STACK_EN
    check("pop_val", 32'(flags), 32'b0101);
`else
    check("pop_val", 32'(flags), 32'b1110);
`endif
    step("push_load", 1, 2'd0, 4'b1111, 4'b0000, 1, 0);
    check("push_load_val", 32'(flags), 32'b0000);
    step("pop2", 1, 2'd1, 4'b1111, 4'b0000, 0, 1);
    step("pop_empty", 1, 2'd1, 4'b1000, 4'b0000, 0, 1);
    check("pop_empty_err", 32'(stk_err), 32'(STK));
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step("fill", 1, 2'd3, 4'b0001, 4'b0000, 1, 0);
      if (i == 3) check("full4", 32'(stk_full), 32'(STK));
      if (i == 3) check("err4", 32'(stk_err), 32'd0);
    end
    check("err5", 32'(stk_err), 32'(STK));
    do_reset();
    step("pre", 1, 2'd0, 4'b0000, 4'b0000, 1, 0);
    step("pushpop", 1, 2'd0, 4'b1111, 4'b0011, 1, 1);
    check("pushpop_val", 32'(flags), 32'b0011);
    check("pushpop_err", 32'(stk_err), 32'(STK));
    enable = 1; op = 2'd1; mask = 4'b1111; push = 1; pop = 0;
    #2;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cond_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 79) == 0) do_reset();
      else step("rand", $urandom_range(0, 7) != 0, 2'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
